// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the programmable clock divider
package clk_div_pkg;

    localparam int MIN_DIV_RATIO = 2;
    localparam int DEFAULT_WIDTH = 8;

    // Number of whole source cycles the posedge phase flop stays high for ratio n.
    function automatic int unsigned half_ratio(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_phase_gen.sv
// rtl/clk_div_phase_gen.sv - negedge phase flop, odd/even combine and bypass output mux
module clk_div_phase_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic q_pos,
    input  logic odd,
    input  logic bypass,
    output logic div_clk
);

    logic q_neg;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg <= 1'b0;
        end else begin
            q_neg <= q_pos;
        end
    end

    // Odd ratios stretch the high phase by half a source cycle via the negedge copy.
    assign div_clk = bypass ? clk : (odd ? (q_pos | q_neg) : q_pos);

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable 50% duty integer clock divider
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clk_en,
    input  logic [WIDTH-1:0] i_div_ratio,
    output logic             o_div_clk,
    output logic             o_ratio_upd
);

    logic [WIDTH-1:0] r_ratio;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] next_ratio;
    logic [WIDTH-1:0] next_cnt;
    logic             r_en;
    logic             next_en;
    logic             bypass;
    logic             boundary;
    logic             q_pos;

    assign bypass   = !r_en || (r_ratio < WIDTH'(MIN_DIV_RATIO));
    assign boundary = bypass || (cnt == (r_ratio - WIDTH'(1)));

    // Settings are only sampled at period boundaries so the output never glitches.
    always_comb begin
        next_ratio = r_ratio;
        next_en    = r_en;
        next_cnt   = cnt + WIDTH'(1);
        if (boundary) begin
            next_ratio = i_div_ratio;
            next_en    = i_clk_en;
            next_cnt   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ratio     <= '0;
            r_en        <= 1'b0;
            cnt         <= '0;
            q_pos       <= 1'b0;
            o_ratio_upd <= 1'b0;
        end else begin
            r_ratio     <= next_ratio;
            r_en        <= next_en;
            cnt         <= next_cnt;
            q_pos       <= (next_cnt < WIDTH'(half_ratio(32'(next_ratio))));
            o_ratio_upd <= boundary && ({i_clk_en, i_div_ratio} != {r_en, r_ratio});
        end
    end

    clk_div_phase_gen u_phase_gen (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .q_pos   (q_pos),
        .odd     (r_ratio[0]),
        .bypass  (bypass),
        .div_clk (o_div_clk)
    );

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog against a half-cycle waveform model
module tb_clk_div_prog;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         clk_en;
    logic [W-1:0] div_ratio;
    logic         div_clk;
    logic         ratio_upd;

    int checks   = 0;
    int failures = 0;

    // Reference: current effective ratio (0 = bypass), posedge index where the period began.
    int unsigned k_pos   = 0;
    int unsigned m_start = 0;
    int unsigned m_n     = 0;
    bit          m_en    = 1'b0;
    int          m_ratio = 0;
    logic        exp_upd = 1'b0;

    longint last_edge = 0;

    clk_div_prog #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clk_en    (clk_en),
        .i_div_ratio (div_ratio),
        .o_div_clk   (div_clk),
        .o_ratio_upd (ratio_upd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Any output pulse narrower than half a source cycle is a glitch.
    always @(div_clk) begin
        if ($time > 0) begin
            if (last_edge > 0) begin
                checks++;
                assert (($time - last_edge) >= 5) else begin
                    failures++;
                    $error("FAIL glitch width=%0d required>=5 t=%0t", $time - last_edge, $time);
                end
            end
            last_edge = $time;
        end
    end

    task automatic model_reset();
        k_pos   = 0;
        m_start = 0;
        m_n     = 0;
        m_en    = 1'b0;
        m_ratio = 0;
        exp_upd = 1'b0;
    endtask

    task automatic model_posedge();
        bit at_boundary;
        k_pos++;
        at_boundary = (m_n == 0) || ((k_pos - m_start) == m_n);
        if (at_boundary) begin
            exp_upd = (clk_en != m_en) || (int'(div_ratio) != m_ratio);
            m_en    = clk_en;
            m_ratio = int'(div_ratio);
            m_n     = (clk_en && div_ratio >= 2) ? int'(div_ratio) : 0;
            m_start = k_pos;
        end else begin
            exp_upd = 1'b0;
        end
    endtask

    // Divided clock is high for the first N half-cycles of each 2N half-cycle period.
    function automatic logic exp_out(input bit low_phase);
        if (m_n == 0) return !low_phase;
        return ((2 * (k_pos - m_start) + low_phase) < m_n);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_posedge();
        #2;
        check("out_high_phase", div_clk, exp_out(1'b0));
        check("ratio_upd", ratio_upd, exp_upd);
        @(negedge clk);
        #2;
        check("out_low_phase", div_clk, exp_out(1'b1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit found;
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        div_ratio = 4'd4;
        model_reset();

        #7;
        check("reset_out_high", div_clk, 1'b1);
        check("reset_upd", ratio_upd, 1'b0);
        #5;
        check("reset_out_low", div_clk, 1'b0);
        rst_n = 1'b1;

        run(12);
        div_ratio = 4'd5;
        run(15);
        div_ratio = 4'd3;
        run(7);
        div_ratio = 4'd6;
        run(14);

        div_ratio = 4'd1;
        run(4);
        div_ratio = 4'd0;
        run(4);
        clk_en    = 1'b0;
        div_ratio = 4'd9;
        run(4);
        clk_en    = 1'b1;
        div_ratio = 4'd7;
        run(16);

        div_ratio = 4'd9;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (m_n == 9 && (k_pos - m_start) == 1) found = 1'b1;
        end
        check("reset_setup_reached", found, 1'b1);
        @(posedge clk);
        model_posedge();
        #2;
        check("pre_reset_high", div_clk, exp_out(1'b0));
        rst_n = 1'b0;
        #1;
        check("midreset_out", div_clk, 1'b1);
        check("midreset_upd", ratio_upd, 1'b0);
        model_reset();
        @(negedge clk);
        #2;
        check("midreset_out_low", div_clk, 1'b0);
        rst_n = 1'b1;
        run(6);

        for (int n = 2; n <= 15; n++) begin
            div_ratio = W'(n);
            run(2 * n + 2);
        end

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                div_ratio = W'($urandom_range(0, 15));
                clk_en    = ($urandom_range(0, 7) != 0);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
